cache_miss_ctrl: RTL
====================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 The block SHALL have a single clock and no parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid / req_write / req_addr[31:0] / req_wdata[7:0]  in  CPU request: read when req_write=0, byte write when req_write=1.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 resp_valid  out  1  one-cycle pulse: request complete.
REQ-007 resp_data  out  8  read byte, valid with resp_valid.
REQ-008 cache_addr  out  32  latched request address driven to the cache.
REQ-009 cache_hit  in  1  combinational cache hit for cache_addr.
REQ-010 cache_rdata  in  8  combinational cache read byte.
REQ-011 cache_wr  out  1  byte-write strobe into the hitting line.
REQ-012 cache_wbyte  out  8  byte to write.
REQ-013 cache_fill  out  1  block-fill strobe.
REQ-014 cache_fill_way  out  1  way to fill.
REQ-015 cache_block  out  256  fill data.
REQ-016 mem_req / mem_we  out  1  memory request and write qualifier.
REQ-017 mem_addr  out  32  memory address.
REQ-018 mem_wdata  out  8  memory write byte.
REQ-019 mem_ack  in  1  one-cycle memory completion.
REQ-020 mem_rdata  in  256  memory block, valid with mem_ack.
REQ-021 hit_count / miss_count  out  16 each  saturating statistics counters.

Function
REQ-022 FSM states SHALL be IDLE, LOOKUP, MEM_RD, FILL, REPLAY, MEM_WR, RESP.
REQ-023 IDLE: req_valid=1 latches addr/write/wdata and moves to LOOKUP; req_ready=0 outside IDLE.
REQ-024 LOOKUP, read hit: resp_data latches cache_rdata, go to RESP, hit_count+1.
REQ-025 LOOKUP, read miss: go to MEM_RD, miss_count+1.
REQ-026 LOOKUP, write hit: cache_wr=1 for exactly this cycle, go to MEM_WR, hit_count+1 (write-through).
REQ-027 LOOKUP, write miss: go to MEM_WR without cache write, miss_count+1 (no write-allocate).
REQ-028 MEM_RD: mem_req=1, mem_we=0, mem_addr={addr[31:5],5'b0}; held until mem_ack; on mem_ack latch mem_rdata, go to FILL.
REQ-029 FILL: cache_fill=1 for one cycle, cache_block=latched data, cache_fill_way=fifo_ptr[addr[7:5]]; that pointer bit SHALL toggle at the end of the cycle; go to REPLAY.
REQ-030 REPLAY: resp_data latches cache_rdata, go to RESP; cache_hit is ignored and the counters do not change.
REQ-031 MEM_WR: mem_req=1, mem_we=1, mem_addr=full addr, mem_wdata=wdata; on mem_ack go to RESP.
REQ-032 RESP: resp_valid=1 for one cycle, then IDLE; resp_data holds its last value afterward.
REQ-033 Latency from acceptance edge to resp_valid SHALL be: read hit 2 cycles; write 3+N cycles; read miss 5+N cycles, where N is the number of mem_req cycles before mem_ack.
REQ-034 fifo_ptr SHALL be 8x1-bit round-robin victim pointers, one per index, touched only in FILL.
REQ-035 Counters SHALL saturate at 16'hFFFF, not wrap.
REQ-036 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-037 All strobes (cache_wr, cache_fill, mem_req, resp_valid) SHALL be mutually exclusive in any cycle.
REQ-038 req_valid while not in IDLE SHALL be ignored and not queued.

Reset
REQ-039 reset=0 SHALL asynchronously force IDLE, clear fifo_ptr, counters, resp_data and all latched request fields, and drive every output to 0 except req_ready=1.
REQ-040 Reset mid-MEM_RD/MEM_WR SHALL drop mem_req immediately; a later stray mem_ack SHALL be ignored.

Verification
REQ-041 Read hit: cache_hit=1, cache_rdata=8'h5A, read 32'h00A00062 -> resp_valid 2 cycles after acceptance, resp_data=8'h5A, hit_count=1.
REQ-042 Read miss: cache_hit=0, mem_ack after 3 cycles with mem_rdata=256'h123456 -> mem_addr=32'h00A00060, cache_fill one cycle with way 0, then resp_valid, miss_count=1.
REQ-043 Two misses to index 3 -> fill ways 0 then 1; a third miss fills way 0.
REQ-044 Write hit, wdata=8'hAA -> one cache_wr pulse with cache_wbyte=8'hAA, then mem_we=1 with mem_wdata=8'hAA, then resp_valid.
REQ-045 Write miss -> no cache_wr and no cache_fill, one memory write, miss_count+1.
REQ-046 Assert reset=0 while in MEM_RD -> mem_req=0 in the same cycle; mem_ack pulsed afterward -> no fill and no resp_valid; counters preset to 16'hFFFF stay at 16'hFFFF on a further hit.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Byte-wide cache controller: read hits from cache, read misses fill a 2-way set via round-robin victim, writes go write-through.
// Latency (acceptance edge to resp_valid): read hit 2, write 3+N, read miss 5+N cycles (N = mem_req cycles before mem_ack).
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are dropped, not queued.
// Ports: clk/reset (async active-low); req_* CPU request in, req_ready/resp_* out; cache_* lookup/write/fill
// interface to a 2-way cache; mem_* block-read / byte-write memory port; hit_count/miss_count saturating stats.
module cache_miss_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [7:0]   req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [7:0]   resp_data,
  output logic [31:0]  cache_addr,
  input  logic         cache_hit,
  input  logic [7:0]   cache_rdata,
  output logic         cache_wr,
  output logic [7:0]   cache_wbyte,
  output logic         cache_fill,
  output logic         cache_fill_way,
  output logic [255:0] cache_block,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [7:0]   mem_wdata,
  input  logic         mem_ack,
  input  logic [255:0] mem_rdata,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] MEM_RD = 3'd2;
  localparam logic [2:0] FILL   = 3'd3;
  localparam logic [2:0] REPLAY = 3'd4;
  localparam logic [2:0] MEM_WR = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

  logic [2:0]   state;
  logic [31:0]  addr_q;
  logic         write_q;
  logic [7:0]   wdata_q;
  logic [7:0]   resp_data_q;
  logic [255:0] block_q;
  logic [7:0]   fifo_ptr;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
  logic [2:0]   idx;

  assign idx = addr_q[7:5];

  // All strobes decode straight from state, so an async reset drops them
  // (including mem_req) in the same cycle and they can never overlap.
  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_data      = resp_data_q;
  assign cache_addr     = addr_q;
  assign cache_wr       = (state == LOOKUP) && write_q && cache_hit;
  assign cache_wbyte    = wdata_q;
  assign cache_fill     = (state == FILL);
  assign cache_fill_way = (state == FILL) && fifo_ptr[idx];
  assign cache_block    = block_q;
  assign mem_req        = (state == MEM_RD) || (state == MEM_WR);
  assign mem_we         = (state == MEM_WR);
  assign mem_wdata      = (state == MEM_WR) ? wdata_q : 8'h00;
  assign hit_count      = hit_cnt;
  assign miss_count     = miss_cnt;

  // Reads fetch the whole 32-byte block; writes are byte-addressed.
  always_comb begin
    mem_addr = 32'h0;
    if (state == MEM_RD)
      mem_addr = {addr_q[31:5], 5'b0};
    else if (state == MEM_WR)
      mem_addr = addr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= 32'h0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      resp_data_q <= 8'h00;
      block_q     <= 256'h0;
      fifo_ptr    <= 8'h00;
      hit_cnt     <= 16'h0;
      miss_cnt    <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cache_hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
          // Writes always go through to memory; no allocate on write miss.
          if (write_q) begin
            state <= MEM_WR;
          end else if (cache_hit) begin
            resp_data_q <= cache_rdata;
            state       <= RESP;
          end else begin
            state <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            block_q <= mem_rdata;
            state   <= FILL;
          end
        end
        FILL: begin
          // Next miss on this index replaces the other way.
          fifo_ptr[idx] <= ~fifo_ptr[idx];
          state         <= REPLAY;
        end
        REPLAY: begin
          // Line was just filled, so the read is known to hit.
          resp_data_q <= cache_rdata;
          state       <= RESP;
        end
        MEM_WR: begin
          if (mem_ack) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
